// File: rtl/cdr_phase_tracker.sv
// Multi-lane oversampling phase tracker: finds data transitions in each lane's
// sample window, filters the sampling phase with hysteresis and reports lock.
module cdr_phase_tracker #(
  parameter int N_PHASE  = 5,
  parameter int N_LANE   = 1,
  parameter int FILT_LEN = 4,
  parameter int LOCK_CNT = 16
) (
  input  logic                              ref_clk,
  input  logic                              rst,
  input  logic [N_LANE*N_PHASE-1:0]         sample_in,
  input  logic                              sample_valid,
  output logic [2*N_LANE-1:0]               data_out,
  output logic [2*N_LANE-1:0]               data_cnt,
  output logic [N_LANE*$clog2(N_PHASE)-1:0] phase_sel,
  output logic [N_LANE-1:0]                 locked
);
  localparam int          PW  = $clog2(N_PHASE);
  localparam int          FCW = $clog2(FILT_LEN + 1);
  localparam int          LCW = $clog2(LOCK_CNT + 1);
  localparam int unsigned NP  = N_PHASE;
  localparam logic [PW-1:0]  HALF     = PW'(N_PHASE / 2);
  localparam logic [PW-1:0]  LAST     = PW'(N_PHASE - 1);
  localparam logic [PW-1:0]  ONE      = PW'(1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CNT);

  function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int unsigned s;
    s = 32'(a) + 32'(b);
    if (s >= NP) s = s - NP;
    return PW'(s);
  endfunction

  // Forward distance from b to a around the phase circle.
  function automatic int unsigned fwd_dist(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (32'(a) + NP - 32'(b)) % NP;
  endfunction

  function automatic int unsigned circ_dist(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int unsigned d;
    d = fwd_dist(a, b);
    if (NP - d < d) d = NP - d;
    return d;
  endfunction

  for (genvar l = 0; l < N_LANE; l++) begin : g_lane
    logic [N_PHASE-1:0] s_q, s_d, sp_q, sp_d;
    logic [PW-1:0]      ps_q, ps_d, pp_q, pp_d, cand_q, cand_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic [LCW-1:0]     lcnt_q, lcnt_d;
    logic               lk_q, lk_d;
    logic [1:0]         dout_q, dout_d, dcnt_q, dcnt_d;
    logic [N_PHASE-1:0] trans;
    logic [PW-1:0]      epos, target;
    logic               edge_hit;
    logic [FCW-1:0]     vote;

    // t[0] pairs the earliest sample with the last sample of the previous window.
    always_comb begin
      trans    = s_q ^ {s_q[N_PHASE-2:0], sp_q[N_PHASE-1]};
      epos     = '0;
      for (int unsigned i = 0; i < NP; i++)
        if (trans[NP-1-i]) epos = PW'(NP - 1 - i);
      edge_hit = |trans;
      target   = add_mod(epos, HALF);
    end

    always_comb begin
      s_d    = s_q;
      sp_d   = sp_q;
      ps_d   = ps_q;
      pp_d   = pp_q;
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      lcnt_d = lcnt_q;
      lk_d   = lk_q;
      dout_d = '0;
      dcnt_d = '0;
      vote   = '0;
      if (sample_valid) begin
        s_d  = sample_in[l*N_PHASE +: N_PHASE];
        sp_d = s_q;
        pp_d = ps_q;
        if (edge_hit) begin
          if (target != ps_q) begin
            if (target == cand_q) begin
              vote = fcnt_q + 1'b1;
            end else begin
              cand_d = target;
              vote   = FCW'(1);
            end
            if (vote >= FILT_MAX) begin
              ps_d   = (fwd_dist(target, ps_q) <= NP / 2) ? add_mod(ps_q, ONE) : add_mod(ps_q, LAST);
              fcnt_d = '0;
            end else begin
              fcnt_d = vote;
            end
          end else begin
            fcnt_d = '0;
          end
          if (circ_dist(epos, add_mod(ps_q, HALF)) <= 1) begin
            if (lcnt_q != LOCK_MAX) lcnt_d = lcnt_q + 1'b1;
            lk_d = (lcnt_d >= LOCK_MAX);
          end else begin
            lcnt_d = '0;
            lk_d   = 1'b0;
          end
        end
        // A phase wrap since the last window either repeats or skips one bit.
        if (pp_q == LAST && ps_q == '0) begin
          dcnt_d = 2'd0;
        end else if (pp_q == '0 && ps_q == LAST) begin
          dout_d = {s_q[N_PHASE-1], sp_q[N_PHASE-1]};
          dcnt_d = 2'd2;
        end else begin
          dout_d = {1'b0, s_q[ps_q]};
          dcnt_d = 2'd1;
        end
      end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
        s_q    <= '0;
        sp_q   <= '0;
        ps_q   <= HALF;
        pp_q   <= HALF;
        cand_q <= HALF;
        fcnt_q <= '0;
        lcnt_q <= '0;
        lk_q   <= 1'b0;
        dout_q <= '0;
        dcnt_q <= '0;
      end else begin
        s_q    <= s_d;
        sp_q   <= sp_d;
        ps_q   <= ps_d;
        pp_q   <= pp_d;
        cand_q <= cand_d;
        fcnt_q <= fcnt_d;
        lcnt_q <= lcnt_d;
        lk_q   <= lk_d;
        dout_q <= dout_d;
        dcnt_q <= dcnt_d;
      end
    end

    assign data_out[2*l +: 2]   = dout_q;
    assign data_cnt[2*l +: 2]   = dcnt_q;
    assign phase_sel[l*PW +: PW] = ps_q;
    assign locked[l]            = lk_q;
  end

endmodule

// File: tb/tb_cdr_phase_tracker.sv
// Directed table-driven bench for cdr_phase_tracker: lane 0 carries the
// stimulus, lane 1 sees constant zeros and must stay quiet.
module tb_cdr_phase_tracker;
  localparam int N_PHASE  = 5;
  localparam int N_LANE   = 2;
  localparam int FILT_LEN = 4;
  localparam int LOCK_CNT = 16;

  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic [3:0] data_out;
  logic [3:0] data_cnt;
  logic [5:0] phase_sel;
  logic [1:0] locked;

  always #5 ref_clk = ~ref_clk;

  cdr_phase_tracker #(
    .N_PHASE (N_PHASE),
    .N_LANE  (N_LANE),
    .FILT_LEN(FILT_LEN),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .ref_clk     (ref_clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .data_out    (data_out),
    .data_cnt    (data_cnt),
    .phase_sel   (phase_sel),
    .locked      (locked)
  );

  typedef struct packed {
    logic [4:0] win;
    logic       valid;
    logic [1:0] dat_e;
    logic [1:0] cnt_e;
    logic [2:0] ps_e;
    logic       lk_e;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] w, input logic v, input logic [1:0] d,
                     input logic [1:0] c, input logic [2:0] p, input logic k);
    vec_t x;
    x.win = w; x.valid = v; x.dat_e = d; x.cnt_e = c; x.ps_e = p; x.lk_e = k;
    tbl.push_back(x);
  endtask

  // Transmitted bit j: 1 for even j, 0 for odd j.
  function automatic logic bitv(input int j);
    return (j >= 0) && (j % 2 == 0);
  endfunction

  // Window with the old bit in samples [0, e) and the new bit in [e, 4].
  function automatic logic [4:0] mkwin(input logic prev, input logic nxt, input int e);
    logic [4:0] w;
    for (int i = 0; i < 5; i++) w[i] = (i < e) ? prev : nxt;
    return w;
  endfunction

  task automatic run_rows(input int lo, input int hi, output int bits);
    vec_t v;
    bits = 0;
    for (int r = lo; r <= hi; r++) begin
      v = tbl[r];
      @(negedge ref_clk);
      sample_in    = {5'b0, v.win};
      sample_valid = v.valid;
      @(posedge ref_clk);
      #1;
      chk("data0", r, data_out[1:0], v.dat_e);
      chk("cnt0", r, data_cnt[1:0], v.cnt_e);
      chk("phase0", r, phase_sel[2:0], v.ps_e);
      chk("lock0", r, locked[0], v.lk_e);
      chk("data1", r, data_out[3:2], 2'd0);
      chk("cnt1", r, data_cnt[3:2], v.valid ? 2'd1 : 2'd0);
      chk("phase1", r, phase_sel[5:3], 3'd2);
      chk("lock1", r, locked[1], 1'b0);
      if (r > lo) bits += int'(data_cnt[1:0]);
    end
  endtask

  task automatic chk_reset_outputs(input int tag);
    chk("rst_data", tag, data_out, 4'd0);
    chk("rst_cnt", tag, data_cnt, 4'd0);
    chk("rst_phase", tag, phase_sel, 6'b010_010);
    chk("rst_lock", tag, locked, 2'b00);
  endtask

  int n1;
  int bits;

  initial begin
    // Sequence 1: clean e=0 data to lock, distance-2 glitch, invalid cycles, relock.
    for (int r = 0; r < 20; r++)
      add({5{bitv(r)}}, 1'b1, (r == 0) ? 2'd0 : {1'b0, bitv(r - 1)}, 2'd1, 3'd2, r >= 16);
    add(5'b11100, 1'b1, 2'd0, 2'd1, 3'd2, 1'b1);
    add(5'b11111, 1'b1, 2'd1, 2'd1, 3'd2, 1'b0);
    add(5'b10101, 1'b0, 2'd0, 2'd0, 3'd2, 1'b0);
    add(5'b10101, 1'b0, 2'd0, 2'd0, 3'd2, 1'b0);
    add(5'b00000, 1'b1, 2'd1, 2'd1, 3'd2, 1'b0);
    for (int k = 25; k <= 40; k++)
      add((k % 2 == 1) ? 5'b11111 : 5'b00000, 1'b1, {1'b0, k % 2 == 0}, 2'd1, 3'd2, k >= 40);
    n1 = tbl.size();

    // Sequence 2 (from reset): drift 2->3->4, forward wrap 4->0, backward wrap 0->4.
    for (int r = 0; r < 30; r++) begin
      int         e;
      logic [1:0] d;
      logic [1:0] c;
      logic [2:0] p;
      e = (r <= 11) ? 2 : (r <= 20) ? 3 : 2;
      c = (r == 17) ? 2'd0 : (r == 26) ? 2'd2 : 2'd1;
      if (r == 0 || r == 17)      d = 2'd0;
      else if (r <= 16)           d = {1'b0, bitv(r - 1)};
      else if (r <= 25)           d = {1'b0, bitv(r - 2)};
      else if (r == 26)           d = {bitv(25), bitv(24)};
      else                        d = {1'b0, bitv(r - 1)};
      p = (r < 4) ? 3'd2 : (r < 8) ? 3'd3 : (r < 16) ? 3'd4 : (r < 25) ? 3'd0 : 3'd4;
      add(mkwin(bitv(r - 1), bitv(r), e), 1'b1, d, c, p, 1'b0);
    end

    repeat (2) @(posedge ref_clk);
    #1;
    chk_reset_outputs(-1);
    @(negedge ref_clk);
    rst = 1'b0;

    run_rows(0, n1 - 1, bits);

    // Asynchronous reset while locked: outputs must clear without a clock edge.
    #1;
    rst          = 1'b1;
    sample_valid = 1'b0;
    #2;
    chk_reset_outputs(-2);
    @(negedge ref_clk);
    @(negedge ref_clk);
    rst = 1'b0;

    run_rows(n1, tbl.size() - 1, bits);
    chk("bit_total", -3, bits, 29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
